// File: rtl/dac_channel_scheduler_pkg.sv
// Shared constants, FSM encoding and channel-pick helpers for the DAC channel scheduler.
package dac_channel_scheduler_pkg;

    localparam logic [3:0] CMD_WRITE = 4'b0011;

    localparam logic [3:0] CH_A_ONEHOT = 4'b0001;
    localparam logic [3:0] CH_B_ONEHOT = 4'b0010;
    localparam logic [3:0] CH_C_ONEHOT = 4'b0100;
    localparam logic [3:0] CH_D_ONEHOT = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } ch_pick_t;

    // Lowest set bit wins, giving ascending A..D service order.
    function automatic ch_pick_t pick_lowest(input logic [3:0] req);
        ch_pick_t p;
        p.found = 1'b0;
        p.idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                p.found = 1'b1;
                p.idx   = 2'(i);
            end
        end
        return p;
    endfunction

    function automatic logic [23:0] make_word(input logic [1:0] ch, input logic [15:0] val);
        logic [3:0] onehot;
        onehot = 4'b0001 << ch;
        return {CMD_WRITE, onehot, val};
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate timer: counts 0..SAMPLE_INTERVAL-1 and flags the last count.
// Latency: tick is combinational from the count register; no backpressure.
module sample_tick_gen #(
    parameter logic [15:0] SAMPLE_INTERVAL = 16'd1909
) (
    input  logic fpga_clock,
    input  logic rst,
    output logic tick
);

    localparam logic [15:0] LAST = SAMPLE_INTERVAL - 16'd1;

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = (count_q == LAST) ? 16'd0 : count_q + 16'd1;
    end

    always_ff @(posedge fpga_clock or posedge rst) begin
        if (rst) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/dac_channel_scheduler.sv
// Time-shares one DAC SPI serialiser across four voices: snapshot on each sample tick, then one write per enabled channel.
// Latency: tick at T -> word at T+1, send pulse at T+2; sends FRAME_CYCLES+2 apart; ticks during a frame are dropped and flagged.
module dac_channel_scheduler
    import dac_channel_scheduler_pkg::*;
#(
    parameter logic [15:0] SAMPLE_INTERVAL = 16'd1909,
    parameter logic [15:0] FRAME_CYCLES    = 16'd60
) (
    input  logic        fpga_clock,
    input  logic        rst,
    input  logic [63:0] ch_data,
    input  logic [3:0]  ch_enable,
    output logic [23:0] dac_data_out,
    output logic        dac_send,
    output logic        sample_tick,
    output logic        frame_done,
    output logic        overrun
);

    localparam logic [15:0] WAIT_LAST = FRAME_CYCLES - 16'd1;

    state_t            state_q, state_d;
    logic [1:0]        ch_q, ch_d;
    logic [15:0]       wait_q, wait_d;
    logic [3:0][15:0]  snap_data_q, snap_data_d;
    logic [3:0]        snap_en_q, snap_en_d;
    logic [23:0]       data_q, data_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;

    logic [3:0][15:0]  ch_vals;
    ch_pick_t          first_pick;
    ch_pick_t          next_pick;

    sample_tick_gen #(
        .SAMPLE_INTERVAL(SAMPLE_INTERVAL)
    ) u_tick (
        .fpga_clock(fpga_clock),
        .rst       (rst),
        .tick      (sample_tick)
    );

    assign ch_vals    = ch_data;
    assign first_pick = pick_lowest(ch_enable);
    assign next_pick  = pick_lowest(snap_en_q & (4'b1110 << ch_q));

    always_ff @(posedge fpga_clock or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ch_q         <= 2'd0;
            wait_q       <= 16'd0;
            snap_data_q  <= '0;
            snap_en_q    <= 4'd0;
            data_q       <= 24'd0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            wait_q       <= wait_d;
            snap_data_q  <= snap_data_d;
            snap_en_q    <= snap_en_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // The word register is loaded on the edge that enters LOAD, so it is
    // already valid during LOAD and holds through SEND and WAIT.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        wait_d       = wait_q;
        snap_data_d  = snap_data_q;
        snap_en_d    = snap_en_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q | (sample_tick & (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (sample_tick && first_pick.found) begin
                    snap_data_d = ch_vals;
                    snap_en_d   = ch_enable;
                    ch_d        = first_pick.idx;
                    data_d      = make_word(first_pick.idx, ch_vals[first_pick.idx]);
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                wait_d  = 16'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    if (next_pick.found) begin
                        ch_d    = next_pick.idx;
                        data_d  = make_word(next_pick.idx, snap_data_q[next_pick.idx]);
                        state_d = ST_LOAD;
                    end else begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        dac_send     = (state_q == ST_SEND);
        dac_data_out = data_q;
        frame_done   = frame_done_q;
        overrun      = overrun_q;
    end

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Directed bench: table of per-frame vectors plus hand sequences for snapshot, overrun and mid-frame reset.
module tb_dac_channel_scheduler;

    logic fpga_clock = 1'b0;
    always #5 fpga_clock = ~fpga_clock;

    logic        rst, rst_ov;
    logic [63:0] ch_data, ov_data;
    logic [3:0]  ch_enable, ov_enable;
    logic [23:0] dac_data_out, ov_dac_data_out;
    logic        dac_send, sample_tick, frame_done, overrun;
    logic        ov_send, ov_tick, ov_frame_done, ov_overrun;

    int errors = 0;
    int checks = 0;

    dac_channel_scheduler dut (
        .fpga_clock  (fpga_clock),
        .rst         (rst),
        .ch_data     (ch_data),
        .ch_enable   (ch_enable),
        .dac_data_out(dac_data_out),
        .dac_send    (dac_send),
        .sample_tick (sample_tick),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    dac_channel_scheduler #(
        .SAMPLE_INTERVAL(16'd20),
        .FRAME_CYCLES   (16'd10)
    ) dut_ov (
        .fpga_clock  (fpga_clock),
        .rst         (rst_ov),
        .ch_data     (ov_data),
        .ch_enable   (ov_enable),
        .dac_data_out(ov_dac_data_out),
        .dac_send    (ov_send),
        .sample_tick (ov_tick),
        .frame_done  (ov_frame_done),
        .overrun     (ov_overrun)
    );

    typedef struct packed {
        logic [3:0]       en;
        logic [63:0]      data;
        logic [2:0]       nsend;
        logic [3:0][23:0] words;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] en, input logic [63:0] data, input logic [2:0] n,
                                input logic [23:0] w0, input logic [23:0] w1,
                                input logic [23:0] w2, input logic [23:0] w3);
        vec_t v;
        v.en    = en;
        v.data  = data;
        v.nsend = n;
        v.words = {w3, w2, w1, w0};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge fpga_clock);
        #1;
    endtask

    task automatic wait_tick(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (sample_tick) ok = 1'b1;
        end
    endtask

    // Applies a vector, waits for the next tick T, then watches T+1..T+260.
    // Sends are expected at T+2+62*i and frame_done 61 cycles after the last send.
    task automatic run_frame(input vec_t v, input bit chg, input logic [3:0] chg_en,
                             input logic [63:0] chg_data, input string tag);
        bit          ok;
        int          nsend;
        int          fd_cycle;
        logic [23:0] got_w [4];
        int          send_cyc [4];
        ch_enable = v.en;
        ch_data   = v.data;
        wait_tick(2000, ok);
        check($sformatf("%s tick_seen", tag), 32'(ok), 32'd1);
        if (!ok) return;
        nsend    = 0;
        fd_cycle = -1;
        for (int c = 1; c <= 260; c++) begin
            step();
            if (chg && c == 5) begin
                ch_enable = chg_en;
                ch_data   = chg_data;
            end
            if (c == 1 && v.nsend != 3'd0)
                check($sformatf("%s word_at_T+1", tag), 32'(dac_data_out), 32'(v.words[0]));
            if (dac_send) begin
                if (nsend < 4) begin
                    got_w[nsend]    = dac_data_out;
                    send_cyc[nsend] = c;
                end
                nsend++;
            end
            if (frame_done && fd_cycle < 0) fd_cycle = c;
        end
        check($sformatf("%s send_count", tag), 32'(nsend), 32'(v.nsend));
        for (int i = 0; i < int'(v.nsend) && i < nsend && i < 4; i++) begin
            check($sformatf("%s word%0d", tag, i), 32'(got_w[i]), 32'(v.words[i]));
            check($sformatf("%s send%0d_cycle", tag, i), 32'(send_cyc[i]), 32'(2 + 62 * i));
        end
        check($sformatf("%s frame_done_cycle", tag), 32'(fd_cycle),
              (v.nsend == 3'd0) ? 32'hFFFF_FFFF : 32'(2 + 62 * (int'(v.nsend) - 1) + 61));
    endtask

    vec_t vecs [6];

    initial begin
        bit ok;
        int n;
        int ns;
        logic [23:0] ov_w [4];
        logic [23:0] ov_exp [4];

        vecs[0] = mk(4'b0001, {16'h0, 16'h0, 16'h0, 16'h1234}, 3'd1,
                     24'h311234, 24'h0, 24'h0, 24'h0);
        vecs[1] = mk(4'b1111, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 3'd4,
                     24'h310001, 24'h320002, 24'h340003, 24'h380004);
        vecs[2] = mk(4'b0101, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 3'd2,
                     24'h31AAAA, 24'h34CCCC, 24'h0, 24'h0);
        vecs[3] = mk(4'b0000, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 3'd0,
                     24'h0, 24'h0, 24'h0, 24'h0);
        vecs[4] = mk(4'b1000, {16'hFFFF, 16'h0, 16'h0, 16'h5555}, 3'd1,
                     24'h38FFFF, 24'h0, 24'h0, 24'h0);
        vecs[5] = mk(4'b0110, {16'h0, 16'h0304, 16'h0102, 16'h0}, 3'd2,
                     24'h320102, 24'h340304, 24'h0, 24'h0);
        ov_exp[0] = 24'h310001;
        ov_exp[1] = 24'h320002;
        ov_exp[2] = 24'h340003;
        ov_exp[3] = 24'h380004;

        rst       = 1'b1;
        rst_ov    = 1'b1;
        ch_enable = 4'd0;
        ch_data   = 64'd0;
        ov_enable = 4'b1111;
        ov_data   = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        repeat (3) step();

        check("rst dac_data_out", 32'(dac_data_out), 32'd0);
        check("rst dac_send",     32'(dac_send),     32'd0);
        check("rst sample_tick",  32'(sample_tick),  32'd0);
        check("rst frame_done",   32'(frame_done),   32'd0);
        check("rst overrun",      32'(overrun),      32'd0);
        check("rst ov_overrun",   32'(ov_overrun),   32'd0);
        rst    = 1'b0;
        rst_ov = 1'b0;

        // Short-interval instance: ticks at T, T+20, T+40 while its frame runs to T+49.
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (ov_tick) ok = 1'b1;
        end
        check("ov first_tick", 32'(ok), 32'd1);
        check("ov overrun_at_T", 32'(ov_overrun), 32'd0);
        ns = 0;
        for (int c = 1; c <= 100; c++) begin
            step();
            if (ov_send && c <= 50) begin
                if (ns < 4) ov_w[ns] = ov_dac_data_out;
                ns++;
            end
            if (c == 20) check("ov overrun_at_second_tick", 32'(ov_overrun), 32'd0);
            if (c == 21) check("ov overrun_after_second_tick", 32'(ov_overrun), 32'd1);
            if (c == 49) check("ov frame_done", 32'(ov_frame_done), 32'd1);
            if (c == 100) check("ov overrun_sticky", 32'(ov_overrun), 32'd1);
        end
        check("ov send_count", 32'(ns), 32'd4);
        for (int i = 0; i < ns && i < 4; i++)
            check($sformatf("ov word%0d", i), 32'(ov_w[i]), 32'(ov_exp[i]));

        for (int k = 0; k < 6; k++)
            run_frame(vecs[k], 1'b0, 4'd0, 64'd0, $sformatf("vec%0d", k));

        // Inputs change at T+5; the running frame must still use tick-time values.
        run_frame(vecs[1], 1'b1, 4'b0001, {4{16'h9999}}, "snap");
        run_frame(mk(4'b0001, {4{16'h9999}}, 3'd1, 24'h319999, 24'h0, 24'h0, 24'h0),
                  1'b0, 4'd0, 64'd0, "snap_next");

        wait_tick(2000, ok);
        n = 0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 2000 && !ok; i++) begin
                step();
                n++;
                if (sample_tick) ok = 1'b1;
            end
        end
        check("tick_period", 32'(n), 32'd1909);

        // Reset during channel B's wait (B sends at T+64, waits T+65..T+124).
        ch_enable = 4'b1111;
        ch_data   = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        wait_tick(2000, ok);
        check("mid rst tick_seen", 32'(ok), 32'd1);
        repeat (80) step();
        check("mid rst word_before", 32'(dac_data_out), 32'h320002);
        rst = 1'b1;
        #1;
        check("mid rst dac_send",     32'(dac_send),     32'd0);
        check("mid rst dac_data_out", 32'(dac_data_out), 32'd0);
        check("mid rst overrun",      32'(overrun),      32'd0);
        check("mid rst frame_done",   32'(frame_done),   32'd0);
        repeat (2) step();
        rst = 1'b0;
        // The release cycle holds count 0, so the tick lands 1908 edges later.
        n  = 0;
        ns = 0;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            step();
            n++;
            if (dac_send || frame_done) ns++;
            if (sample_tick) ok = 1'b1;
        end
        check("post rst first_tick_edges", 32'(n), 32'd1908);
        check("post rst no_send", 32'(ns), 32'd0);
        check("main overrun_never", 32'(overrun), 32'd0);
        check("ov overrun_still_set", 32'(ov_overrun), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
